// File: rtl/vec_store_ctrl_if.sv
// Command and read-result handshake between the host command decoder and vec_store_ctrl.
interface vec_store_ctrl_if #(
   parameter int VEC_W = 128,
   parameter int TAG_W = 2
);
   logic               CMD_VALID;
   logic               CMD_READY;
   logic [2:0]         CMD_OP;
   logic [TAG_W-1:0]   CMD_TAG;
   logic [2*VEC_W-1:0] WR_DATA;
   logic               RD_VALID;
   logic               RD_READY;
   logic [2*VEC_W-1:0] RD_DATA;
   logic               TEMPLATE_CHANGE;

   modport master (
      output CMD_VALID, CMD_OP, CMD_TAG, WR_DATA, RD_READY,
      input  CMD_READY, RD_VALID, RD_DATA, TEMPLATE_CHANGE
   );

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_TAG, WR_DATA, RD_READY,
      output CMD_READY, RD_VALID, RD_DATA, TEMPLATE_CHANGE
   );
endinterface

// File: rtl/vec_store_ctrl.sv
// Sequences input vectors (circular FIFO), template words and FF pairs into a
// single-port synchronous BRAM, one BRAM_W beat per cycle.
module vec_store_ctrl #(
   parameter int                VEC_W     = 128,
   parameter int                BRAM_W    = 64,
   parameter int                ADDR_W    = 13,
   parameter int                TAG_W     = 2,
   parameter int                VEC_DEPTH = 256,
   parameter logic [ADDR_W-1:0] TMPL_BASE = 13'h1000,
   parameter logic [ADDR_W-1:0] FF_BASE   = 13'h1800,
   localparam int               CNT_W     = $clog2(VEC_DEPTH+1)
) (
   input  logic              CLK,
   input  logic              RST,
   vec_store_ctrl_if.slave   bus,
   output logic              ERR,
   output logic [CNT_W-1:0]  Q_COUNT,
   output logic              Q_FULL,
   output logic              Q_EMPTY,
   output logic              BRAM_EN,
   output logic              BRAM_WE,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic [BRAM_W-1:0] BRAM_DIN,
   input  logic [BRAM_W-1:0] BRAM_DOUT
);
   localparam int BEATS  = VEC_W / BRAM_W;
   localparam int PTR_W  = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;
   localparam int BEAT_W = $clog2(2*BEATS+1);
   localparam int IDX_W  = $clog2(2*BEATS);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_HOLD} state_t;
   typedef enum logic [2:0] {
      OP_INPUT_WR, OP_TMPL_WR, OP_FF_WR,
      OP_INPUT_RD, OP_TMPL_RD, OP_FF_RD,
      OP_CLEAR, OP_RSVD
   } op_t;
   typedef struct packed {
      op_t                            op;
      logic [TAG_W-1:0]               tag;
      logic [2*BEATS-1:0][BRAM_W-1:0] data;
   } cmd_t;

   state_t                         state, state_nxt;
   cmd_t                           cmd_q;
   op_t                            op_in;
   logic [BEAT_W-1:0]              beat, n_beats;
   logic [PTR_W-1:0]               wr_ptr, rd_ptr;
   logic [CNT_W-1:0]               q_cnt;
   logic                           cap_vld;
   logic [IDX_W-1:0]               cap_idx;
   logic [2*BEATS-1:0][BRAM_W-1:0] rd_data_q;
   logic                           tmpl_chg_q, err_q, tag_seen;
   logic [TAG_W-1:0]               prev_tag, tag_now;
   logic                           accept, rej, acc_wr, acc_rd, last_beat, q_full, q_empty;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(VEC_DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign op_in     = op_t'(bus.CMD_OP);
   assign q_full    = (q_cnt == CNT_W'(VEC_DEPTH));
   assign q_empty   = (q_cnt == '0);
   assign accept    = bus.CMD_VALID && (state == S_IDLE);
   assign rej       = (op_in == OP_INPUT_WR && q_full) || (op_in == OP_INPUT_RD && q_empty) ||
                      (op_in == OP_RSVD);
   assign acc_wr    = accept && !rej && (op_in inside {OP_INPUT_WR, OP_TMPL_WR, OP_FF_WR});
   assign acc_rd    = accept && !rej && (op_in inside {OP_INPUT_RD, OP_TMPL_RD, OP_FF_RD});
   assign n_beats   = (cmd_q.op inside {OP_FF_WR, OP_FF_RD}) ? BEAT_W'(2*BEATS) : BEAT_W'(BEATS);
   assign last_beat = (beat == n_beats - BEAT_W'(1));
   // The last input-vector beat is always the top slice, so the tag comes straight off DOUT.
   assign tag_now   = BRAM_DOUT[BRAM_W-1 -: TAG_W];

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      BRAM_EN   = 1'b0;
      BRAM_WE   = 1'b0;
      case (state)
         S_IDLE: begin
            if (acc_wr)      state_nxt = S_WRITE;
            else if (acc_rd) state_nxt = S_READ;
         end
         S_WRITE: begin
            BRAM_EN = 1'b1;
            BRAM_WE = 1'b1;
            if (last_beat) state_nxt = S_IDLE;
         end
         S_READ: begin
            // One extra cycle after the final issue lets the last beat land.
            if (beat < n_beats) BRAM_EN = 1'b1;
            else                state_nxt = S_HOLD;
         end
         S_HOLD:  if (bus.RD_READY) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      case (cmd_q.op)
         OP_INPUT_WR: BRAM_ADDR = ADDR_W'(wr_ptr) * ADDR_W'(BEATS) + ADDR_W'(beat);
         OP_INPUT_RD: BRAM_ADDR = ADDR_W'(rd_ptr) * ADDR_W'(BEATS) + ADDR_W'(beat);
         OP_TMPL_WR, OP_TMPL_RD:
            BRAM_ADDR = TMPL_BASE + ADDR_W'(cmd_q.tag) * ADDR_W'(BEATS) + ADDR_W'(beat);
         default:
            BRAM_ADDR = FF_BASE + ADDR_W'(cmd_q.tag) * ADDR_W'(2*BEATS) + ADDR_W'(beat);
      endcase
   end

   assign BRAM_DIN = cmd_q.data[beat[IDX_W-1:0]];

   always_ff @(posedge CLK) begin
      if (RST) begin
         cmd_q      <= '0;
         beat       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         q_cnt      <= '0;
         cap_vld    <= 1'b0;
         cap_idx    <= '0;
         rd_data_q  <= '0;
         tmpl_chg_q <= 1'b0;
         err_q      <= 1'b0;
         tag_seen   <= 1'b0;
         prev_tag   <= '0;
      end else begin
         err_q   <= accept && rej;
         cap_vld <= (state == S_READ) && (beat < n_beats);
         cap_idx <= beat[IDX_W-1:0];
         if (accept) begin
            cmd_q      <= '{op: op_in, tag: bus.CMD_TAG, data: bus.WR_DATA};
            beat       <= '0;
            tmpl_chg_q <= 1'b0;
         end
         if (acc_rd) rd_data_q <= '0;
         if (accept && op_in == OP_CLEAR) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            tag_seen <= 1'b0;
         end
         if (state == S_WRITE) begin
            beat <= beat + BEAT_W'(1);
            if (last_beat && cmd_q.op == OP_INPUT_WR) begin
               wr_ptr <= ptr_inc(wr_ptr);
               q_cnt  <= q_cnt + CNT_W'(1);
            end
         end
         if (state == S_READ && beat < n_beats) begin
            beat <= beat + BEAT_W'(1);
            if (last_beat && cmd_q.op == OP_INPUT_RD) begin
               rd_ptr <= ptr_inc(rd_ptr);
               q_cnt  <= q_cnt - CNT_W'(1);
            end
         end
         if (cap_vld) rd_data_q[cap_idx] <= BRAM_DOUT;
         if (state == S_READ && beat == n_beats && cmd_q.op == OP_INPUT_RD) begin
            tmpl_chg_q <= !tag_seen || (tag_now != prev_tag);
            prev_tag   <= tag_now;
            tag_seen   <= 1'b1;
         end
      end
   end

   assign bus.CMD_READY       = (state == S_IDLE);
   assign bus.RD_VALID        = (state == S_HOLD);
   assign bus.RD_DATA         = rd_data_q;
   assign bus.TEMPLATE_CHANGE = tmpl_chg_q;
   assign ERR                 = err_q;
   assign Q_COUNT             = q_cnt;
   assign Q_FULL              = q_full;
   assign Q_EMPTY             = q_empty;
endmodule

// File: tb/tb_vec_store_ctrl.sv
// Random and directed command traffic against a vector-level model of the store
// (FIFO queue, template/FF arrays, last-seen tag), with a behavioural BRAM.
module tb_vec_store_ctrl;
   localparam int          VEC_W = 128, BRAM_W = 64, ADDR_W = 13, TAG_W = 2;
   localparam int          VEC_DEPTH = 4, BEATS = 2;
   localparam int          CNT_W = $clog2(VEC_DEPTH+1);
   localparam int          TMPL_BASE = 'h1000, FF_BASE = 'h1800;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   vec_store_ctrl_if #(.VEC_W(VEC_W), .TAG_W(TAG_W)) bus ();
   logic              ERR, Q_FULL, Q_EMPTY, BRAM_EN, BRAM_WE;
   logic [CNT_W-1:0]  Q_COUNT;
   logic [ADDR_W-1:0] BRAM_ADDR;
   logic [BRAM_W-1:0] BRAM_DIN, BRAM_DOUT;

   vec_store_ctrl #(
      .VEC_W(VEC_W), .BRAM_W(BRAM_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .VEC_DEPTH(VEC_DEPTH),
      .TMPL_BASE(13'h1000), .FF_BASE(13'h1800)
   ) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .ERR(ERR), .Q_COUNT(Q_COUNT), .Q_FULL(Q_FULL),
      .Q_EMPTY(Q_EMPTY), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
      .BRAM_DIN(BRAM_DIN), .BRAM_DOUT(BRAM_DOUT)
   );

   // Synchronous single-port BRAM, read-before-write, unwritten words read as zero.
   logic [63:0] mem [int];
   always @(posedge CLK) begin
      if (BRAM_EN) begin
         BRAM_DOUT <= mem.exists(int'(BRAM_ADDR)) ? mem[int'(BRAM_ADDR)] : 64'h0;
         if (BRAM_WE) mem[int'(BRAM_ADDR)] = BRAM_DIN;
      end
   end

   int n_chk = 0, n_pass = 0;
   logic [127:0] fifo [$];
   int           wr_slot, rd_slot;
   logic [127:0] tmpl_m [4];
   logic [255:0] ff_m [4];
   bit           seen;
   logic [1:0]   prev;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [127:0] mkvec(input logic [1:0] t);
      return {t, 30'($urandom), $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      fifo.delete();
      wr_slot = 0;
      rd_slot = 0;
      seen    = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [1:0] tag, input logic [255:0] d);
      int w = 0;
      while (!bus.CMD_READY && w < 50) begin @(negedge CLK); w++; end
      if (!bus.CMD_READY) chk("cmd_ready_timeout", 256'(bus.CMD_READY), 256'(1));
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = op;
      bus.CMD_TAG   = tag;
      bus.WR_DATA   = d;
      @(negedge CLK);
      bus.CMD_VALID = 1'b0;
      bus.CMD_TAG   = 2'($urandom);
      bus.WR_DATA   = {mkvec(2'($urandom)), mkvec(2'($urandom))};
   endtask

   task automatic do_wr(input logic [2:0] op, input logic [1:0] tag, input logic [255:0] d);
      int n    = (op == 3'd2) ? 2*BEATS : BEATS;
      bit rej  = (op == 3'd0) && (fifo.size() == VEC_DEPTH);
      int base = (op == 3'd0) ? wr_slot*BEATS :
                 (op == 3'd1) ? TMPL_BASE + int'(tag)*BEATS : FF_BASE + int'(tag)*2*BEATS;
      send(op, tag, d);
      if (rej) begin
         chk("wr_full_err", 256'(ERR), 256'(1));
         chk("wr_full_we", 256'(BRAM_WE), 256'(0));
         chk("wr_full_rdy", 256'(bus.CMD_READY), 256'(1));
         chk("wr_full_cnt", 256'(Q_COUNT), 256'(fifo.size()));
         return;
      end
      chk("wr_no_err", 256'(ERR), 256'(0));
      for (int b = 0; b < n; b++) begin
         chk("wr_en_we", 256'({BRAM_EN, BRAM_WE}), 256'(2'b11));
         chk("wr_addr", 256'(BRAM_ADDR), 256'(base + b));
         chk("wr_din", 256'(BRAM_DIN), 256'(d[b*64 +: 64]));
         @(negedge CLK);
      end
      case (op)
         3'd0: begin fifo.push_back(d[127:0]); wr_slot = (wr_slot + 1) % VEC_DEPTH; end
         3'd1: tmpl_m[tag] = d[127:0];
         default: ff_m[tag] = d;
      endcase
      chk("wr_done_rdy", 256'(bus.CMD_READY), 256'(1));
      chk("wr_cnt", 256'(Q_COUNT), 256'(fifo.size()));
      chk("wr_full", 256'(Q_FULL), 256'(fifo.size() == VEC_DEPTH));
   endtask

   task automatic do_rd(input logic [2:0] op, input logic [1:0] tag, input int hold);
      int n    = (op == 3'd5) ? 2*BEATS : BEATS;
      bit rej  = (op == 3'd3) && (fifo.size() == 0);
      int base = 0;
      logic [255:0] exp = '0;
      bit exp_tc = 1'b0;
      send(op, tag, '0);
      if (rej) begin
         chk("rd_empty_err", 256'(ERR), 256'(1));
         chk("rd_empty_vld", 256'(bus.RD_VALID), 256'(0));
         repeat (3) @(negedge CLK);
         chk("rd_empty_vld_late", 256'(bus.RD_VALID), 256'(0));
         return;
      end
      chk("rd_no_err", 256'(ERR), 256'(0));
      case (op)
         3'd3: begin
            exp     = {128'h0, fifo.pop_front()};
            base    = rd_slot*BEATS;
            rd_slot = (rd_slot + 1) % VEC_DEPTH;
            exp_tc  = !seen || (exp[127:126] != prev);
            seen    = 1'b1;
            prev    = exp[127:126];
         end
         3'd4: begin exp = {128'h0, tmpl_m[tag]}; base = TMPL_BASE + int'(tag)*BEATS; end
         default: begin exp = ff_m[tag]; base = FF_BASE + int'(tag)*2*BEATS; end
      endcase
      for (int b = 0; b < n; b++) begin
         chk("rd_en_we", 256'({BRAM_EN, BRAM_WE}), 256'(2'b10));
         chk("rd_addr", 256'(BRAM_ADDR), 256'(base + b));
         @(negedge CLK);
      end
      chk("rd_vld_early", 256'(bus.RD_VALID), 256'(0));
      @(negedge CLK);
      chk("rd_vld", 256'(bus.RD_VALID), 256'(1));
      chk("rd_data", bus.RD_DATA, exp);
      chk("rd_tc", 256'(bus.TEMPLATE_CHANGE), 256'(exp_tc));
      chk("rd_cnt", 256'(Q_COUNT), 256'(fifo.size()));
      chk("rd_empty", 256'(Q_EMPTY), 256'(fifo.size() == 0));
      for (int h = 0; h < hold; h++) begin
         @(negedge CLK);
         chk("hold_data", bus.RD_DATA, exp);
         chk("hold_vld_rdy", 256'({bus.RD_VALID, bus.CMD_READY}), 256'(2'b10));
      end
      bus.RD_READY = 1'b1;
      @(negedge CLK);
      bus.RD_READY = 1'b0;
      chk("rd_done", 256'({bus.RD_VALID, bus.CMD_READY}), 256'(2'b01));
   endtask

   task automatic do_clear();
      send(3'd6, 2'd0, '0);
      model_reset();
      chk("clr_cnt", 256'(Q_COUNT), 256'(0));
      chk("clr_flags", 256'({Q_EMPTY, Q_FULL, ERR, bus.CMD_READY}), 256'(4'b1001));
   endtask

   task automatic do_rsvd();
      send(3'd7, 2'($urandom), '0);
      chk("rsvd_err", 256'(ERR), 256'(1));
      chk("rsvd_cnt", 256'(Q_COUNT), 256'(fifo.size()));
      chk("rsvd_we", 256'(BRAM_WE), 256'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(tag, 256'({bus.CMD_READY, bus.RD_VALID, bus.TEMPLATE_CHANGE, ERR, Q_EMPTY, Q_FULL,
                     BRAM_EN, BRAM_WE}), 256'(8'b1000_1000));
      chk({tag, "_cnt"}, 256'(Q_COUNT), 256'(0));
      chk({tag, "_data"}, bus.RD_DATA, 256'(0));
   endtask

   initial begin
      bus.CMD_VALID = 1'b0;
      bus.CMD_OP    = 3'd0;
      bus.CMD_TAG   = 2'd0;
      bus.WR_DATA   = '0;
      bus.RD_READY  = 1'b0;
      for (int t = 0; t < 4; t++) begin tmpl_m[t] = '0; ff_m[t] = '0; end
      model_reset();
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      RST = 1'b0;
      @(negedge CLK);

      // First vector round trip.
      do_wr(3'd0, 2'd0, {128'h0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
      do_rd(3'd3, 2'd0, 0);

      // Fill, overflow, drain, underflow.
      for (int i = 0; i < 5; i++) do_wr(3'd0, 2'd0, {128'h0, mkvec(2'($urandom))});
      for (int i = 0; i < 5; i++) do_rd(3'd3, 2'd0, 0);

      // Pointer wrap with alternating traffic from slot 0.
      do_clear();
      for (int i = 0; i < 6; i++) begin
         do_wr(3'd0, 2'd0, {128'h0, mkvec(2'($urandom))});
         do_rd(3'd3, 2'd0, 0);
      end

      // Template-change sequence 01, 01, 11, then CLEAR and 11 again.
      do_clear();
      do_wr(3'd0, 2'd0, {128'h0, mkvec(2'b01)});
      do_wr(3'd0, 2'd0, {128'h0, mkvec(2'b01)});
      do_wr(3'd0, 2'd0, {128'h0, mkvec(2'b11)});
      for (int i = 0; i < 3; i++) do_rd(3'd3, 2'd0, 0);
      do_clear();
      do_wr(3'd0, 2'd0, {128'h0, mkvec(2'b11)});
      do_rd(3'd3, 2'd0, 0);

      // FF pair for tag 3, template for tag 1 (with overwrite), long hold.
      do_wr(3'd2, 2'd3, {mkvec(2'd2), mkvec(2'd1)});
      do_rd(3'd5, 2'd3, 0);
      do_wr(3'd1, 2'd1, {128'h0, mkvec(2'd0)});
      do_wr(3'd1, 2'd1, {128'h0, mkvec(2'd3)});
      do_rd(3'd4, 2'd1, 10);
      do_rsvd();

      // Reset during write beat 0.
      do_wr(3'd0, 2'd0, {128'h0, mkvec(2'd2)});
      send(3'd0, 2'd0, {128'h0, mkvec(2'd1)});
      RST = 1'b1;
      @(negedge CLK);
      model_reset();
      check_reset_outputs("mid_reset");
      RST = 1'b0;
      @(negedge CLK);
      do_wr(3'd0, 2'd0, {128'h0, mkvec(2'd1)});
      do_rd(3'd3, 2'd0, 0);

      for (int it = 0; it < 300; it++) begin
         int r = $urandom_range(0, 99);
         logic [1:0] tg = 2'($urandom);
         if      (r < 30) do_wr(3'd0, tg, {mkvec(2'($urandom)), mkvec(2'($urandom))});
         else if (r < 58) do_rd(3'd3, tg, $urandom_range(0, 2));
         else if (r < 66) do_wr(3'd1, tg, {mkvec(2'($urandom)), mkvec(2'($urandom))});
         else if (r < 74) do_rd(3'd4, tg, $urandom_range(0, 2));
         else if (r < 81) do_wr(3'd2, tg, {mkvec(2'($urandom)), mkvec(2'($urandom))});
         else if (r < 88) do_rd(3'd5, tg, $urandom_range(0, 2));
         else if (r < 92) do_clear();
         else if (r < 95) do_rsvd();
         else repeat ($urandom_range(1, 3)) @(negedge CLK);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vec_store_ctrl.md
Name: vec_store_ctrl

Overview:
- Parametrised controller that stores tester data in an external single-port synchronous BRAM. Data classes: input vectors in a circular FIFO, per-template configuration words, and per-template FF configuration pairs.
- Replaces fixed 128-bit/64-bit hard-wired sequencing. Adds a valid/ready command handshake, FIFO occupancy tracking with full/empty error reporting, a held read result, and correct first-read template-change detection.
- Sits between the host command decoder and the BRAM primitive.

Parameters:
- VEC_W, 128: vector width in bits. Must be a multiple of BRAM_W.
- BRAM_W, 64: BRAM data port width. BEATS = VEC_W/BRAM_W.
- ADDR_W, 13: BRAM word address width.
- TAG_W, 2: template tag width. Templates = 2**TAG_W. The tag is carried in the vector's top TAG_W bits.
- VEC_DEPTH, 256: input-vector FIFO slots. Need not be a power of two.
- TMPL_BASE, 13'h1000: word base of the template region. Entry t occupies TMPL_BASE + t*BEATS + b.
- FF_BASE, 13'h1800: word base of the FF region. Entry t occupies FF_BASE + t*2*BEATS + b.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when VALID&&READY.
- CMD_OP  in  3  command opcode:
  - 0 INPUT_WR, 1 TMPL_WR, 2 FF_WR
  - 3 INPUT_RD, 4 TMPL_RD, 5 FF_RD
  - 6 CLEAR; 7 reserved.
- CMD_TAG  in  TAG_W  template index for TMPL_*/FF_* ops.
- WR_DATA  in  2*VEC_W  write payload. [VEC_W-1:0] is used by all writes; the upper half is used by FF_WR only.
- RD_VALID  out  1  read result available.
- RD_READY  in  1  consumer accepts the read result.
- RD_DATA  out  2*VEC_W  read result. The upper half is zero except for FF_RD.
- TEMPLATE_CHANGE  out  1  qualified by RD_VALID. Meaningful for INPUT_RD only.
- ERR  out  1  one-cycle pulse on an illegal command.
- Q_COUNT  out  clog2(VEC_DEPTH+1)  FIFO occupancy.
- Q_FULL, Q_EMPTY  out  1  FIFO flags.
- BRAM_EN, BRAM_WE  out  1  BRAM controls.
- BRAM_ADDR  out  ADDR_W  BRAM address.
- BRAM_DIN  out  BRAM_W  BRAM write data.
- BRAM_DOUT  in  BRAM_W  BRAM read data, valid one cycle after the address.

Behaviour:
- Reset values:
  - CMD_READY=1, RD_VALID=0, RD_DATA=0, TEMPLATE_CHANGE=0, ERR=0.
  - Q_COUNT=0, Q_EMPTY=1, Q_FULL=0, BRAM_EN=0, BRAM_WE=0.
  - wr_ptr=rd_ptr=0; tag_seen=0.
- Reset mid-operation aborts at the next edge. BRAM_WE is deasserted from the first post-reset cycle; partial vectors are discarded and pointers are not advanced.
- States: IDLE, WRITE, READ, HOLD.
- CMD_READY = (state==IDLE).
- On accept, latch CMD_OP, CMD_TAG and WR_DATA. The live inputs are ignored afterwards.
- Total beats N: BEATS for input/template ops, 2*BEATS for FF ops.
- Beat b's address:
  - INPUT ops: slot*BEATS+b.
  - TMPL ops: TMPL_BASE + tag*BEATS + b.
  - FF ops: FF_BASE + tag*2*BEATS + b.
- Beat b carries data slice [b*BRAM_W +: BRAM_W].
- IDLE -> WRITE (ops 0-2):
  - One beat per cycle, BRAM_EN=BRAM_WE=1, beat counter 0..N-1.
  - Returns to IDLE after the last beat.
  - Accept at cycle 0, beats in cycles 1..N, CMD_READY=1 in cycle N+1.
- IDLE -> READ (ops 3-5):
  - Addresses issued in cycles 1..N with BRAM_EN=1, BRAM_WE=0.
  - BRAM_DOUT captured into RD_DATA slice b one cycle after issue, i.e. pipelined.
  - State goes to HOLD after the final capture.
  - RD_VALID=1 from cycle N+2; held with RD_DATA stable until RD_VALID&&RD_READY, then IDLE.
- INPUT_WR:
  - If Q_FULL: no BRAM activity, ERR pulses in cycle 1, return to IDLE in cycle 1.
  - Otherwise wr_ptr advances after the last beat, wrapping VEC_DEPTH-1 -> 0.
- INPUT_RD:
  - If Q_EMPTY: ERR pulse, no RD_VALID.
  - Otherwise rd_ptr advances after the last beat, with the same wrap rule.
- Q_COUNT changes only at pointer advances: +1 on write completion, -1 on read completion. It never exceeds VEC_DEPTH.
- Q_FULL = (Q_COUNT==VEC_DEPTH); Q_EMPTY = (Q_COUNT==0).
- TEMPLATE_CHANGE for INPUT_RD:
  - Computed when RD_VALID rises from tag = RD_DATA[VEC_W-1 -: TAG_W].
  - Value is 1 if tag_seen==0 or tag != prev_tag.
  - Then prev_tag <= tag, tag_seen <= 1.
  - Forced to 0 for TMPL_RD and FF_RD.
- CLEAR: takes one cycle. Resets wr_ptr, rd_ptr, Q_COUNT and tag_seen; does not touch BRAM, template or FF data.
- Opcode 7: ERR pulse, no other effect.
- Template/FF writes to an existing tag overwrite in place. Reads of never-written entries return BRAM contents as-is.

Test Plan:
- Defaults VEC_DEPTH=4, VEC_W=128, BRAM_W=64. INPUT_WR 0x1111..._2222...(tag 2'b00), then INPUT_RD:
  - BRAM writes to addresses 0,1 in cycles 1,2.
  - RD_VALID in cycle 4 with identical 128-bit data in RD_DATA[127:0], TEMPLATE_CHANGE=1, Q_COUNT 1->0.
- Write 4 vectors, then a 5th:
  - Q_FULL=1 after the 4th.
  - 5th gives an ERR pulse, no BRAM_WE, Q_COUNT stays 4.
  - Read 5 times: 4 results in order, 5th gives ERR with no RD_VALID.
- Wrap: write/read 6 vectors alternately. 5th write targets addresses 0,1 again; data returned matches each write.
- Consecutive input reads with tags 01,01,11 -> TEMPLATE_CHANGE = 1,0,1. After CLEAR, the next read with tag 11 gives 1.
- FF_WR tag 3 with a 256-bit payload -> 4 beats at FF_BASE+12..15. FF_RD tag 3 returns the full 256 bits, RD_VALID in cycle 6, TEMPLATE_CHANGE=0.
- Hold RD_READY=0 for 10 cycles: RD_DATA stable, CMD_READY=0. Separately, assert RST during WRITE beat 0: pointers unchanged, all outputs at reset values next cycle.
